sram_axi_bridge: RTL

//  Merges the CPU's two SRAM-like masters (inst_sram_*, data_sram_*; req/addr_ok/data_ok) onto one AXI3 master port.

---
 rtl/sram_axi_bridge_pkg.sv | 21 ++
 rtl/sram_axi_bridge_rd_tracker.sv | 55 +++++
 rtl/sram_axi_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// ============================================================================
// Module      : sram_axi_bridge_pkg
// Description : Shared AXI constants and write-FSM state encodings for the bridge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int         INST_ID    = 0;
    localparam int         DATA_ID    = 1;

    typedef logic [1:0] wstate_t;
    localparam wstate_t W_IDLE = 2'd0;
    localparam wstate_t W_SEND = 2'd1;
    localparam wstate_t W_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sram_axi_bridge_rd_tracker.sv
// ============================================================================
// Module      : sram_axi_bridge_rd_tracker
// Description : Per-channel outstanding-read counter with registered data_ok/rdata
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_axi_bridge_rd_tracker #(
    parameter int DATA_W = 32,
    parameter int MAX_RD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_acc,
    input  logic              i_hit,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_can_acc,
    output logic              o_cnt_zero,
    output logic              o_data_ok,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int CNT_W = $clog2(MAX_RD + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_data_ok;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (i_acc && !r_data_ok) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!i_acc && r_data_ok) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_data_ok <= i_hit;
            if (i_hit) begin
                r_rdata <= i_rdata;
            end
        end
    end

    // A slot freed by this cycle's data_ok can be reused in the same cycle.
    assign o_can_acc  = (r_cnt < CNT_W'(MAX_RD)) || r_data_ok;
    assign o_cnt_zero = (r_cnt == '0);
    assign o_data_ok  = r_data_ok;
    assign o_rdata    = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_axi_bridge.sv
// ============================================================================
// Module      : sram_axi_bridge
// Description : Merges inst/data SRAM-like masters onto a single AXI3 master port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int MAX_RD = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_sram_req,
    input  logic                inst_sram_wr,
    input  logic [1:0]          inst_sram_size,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    input  logic [3:0]          inst_sram_wstrb,
    input  logic [DATA_W-1:0]   inst_sram_wdata,
    output logic                inst_sram_addr_ok,
    output logic                inst_sram_data_ok,
    output logic [DATA_W-1:0]   inst_sram_rdata,

    input  logic                data_sram_req,
    input  logic                data_sram_wr,
    input  logic [1:0]          data_sram_size,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W/8-1:0] data_sram_wstrb,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic                data_sram_addr_ok,
    output logic                data_sram_data_ok,
    output logic [DATA_W-1:0]   data_sram_rdata,

    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam logic [ID_W-1:0] c_inst_id = ID_W'(INST_ID);
    localparam logic [ID_W-1:0] c_data_id = ID_W'(DATA_ID);

    logic                r_ar_valid;
    logic [ID_W-1:0]     r_ar_id;
    logic [ADDR_W-1:0]   r_ar_addr;
    logic [2:0]          r_ar_size;

    logic                r_aw_valid;
    logic                r_w_valid;
    logic [ADDR_W-1:0]   r_aw_addr;
    logic [2:0]          r_aw_size;
    logic [DATA_W/8-1:0] r_w_strb;
    logic [DATA_W-1:0]   r_w_data;
    logic                r_wr_data_ok;

    wstate_t             r_wstate;
    wstate_t             w_wnext;
    logic                w_wr_idle;
    logic                w_b_hit;

    logic                w_ar_free;
    logic                w_inst_can;
    logic                w_data_can;
    logic                w_data_cnt_zero;
    logic                w_inst_cnt_zero;
    logic                w_inst_rd_acc;
    logic                w_data_rd_acc;
    logic                w_data_wr_acc;
    logic                w_data_rd_ok;
    logic [DATA_W-1:0]   w_data_rd_data;

    // Acceptance and arbitration: data reads outrank inst reads for the single AR slot.
    assign w_ar_free     = !r_ar_valid || arready;
    assign w_data_rd_acc = data_sram_req && !data_sram_wr && w_wr_idle && w_data_can && w_ar_free;
    assign w_inst_rd_acc = inst_sram_req && w_inst_can && w_ar_free && !w_data_rd_acc;
    assign w_data_wr_acc = data_sram_req && data_sram_wr && w_wr_idle && w_data_cnt_zero
                           && !(r_ar_valid && (r_ar_id == c_data_id));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar_valid <= 1'b0;
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_size  <= '0;
        end else if (w_data_rd_acc) begin
            r_ar_valid <= 1'b1;
            r_ar_id    <= c_data_id;
            r_ar_addr  <= data_sram_addr;
            r_ar_size  <= {1'b0, data_sram_size};
        end else if (w_inst_rd_acc) begin
            r_ar_valid <= 1'b1;
            r_ar_id    <= c_inst_id;
            r_ar_addr  <= inst_sram_addr;
            r_ar_size  <= {1'b0, inst_sram_size};
        end else if (arready) begin
            r_ar_valid <= 1'b0;
        end
    end

    sram_axi_bridge_rd_tracker #(
        .DATA_W (DATA_W),
        .MAX_RD (MAX_RD)
    ) u_inst_trk (
        .clk        (clk),
        .rst        (reset),
        .i_acc      (w_inst_rd_acc),
        .i_hit      (rvalid && (rid == c_inst_id)),
        .i_rdata    (rdata),
        .o_can_acc  (w_inst_can),
        .o_cnt_zero (w_inst_cnt_zero),
        .o_data_ok  (inst_sram_data_ok),
        .o_rdata    (inst_sram_rdata)
    );

    sram_axi_bridge_rd_tracker #(
        .DATA_W (DATA_W),
        .MAX_RD (MAX_RD)
    ) u_data_trk (
        .clk        (clk),
        .rst        (reset),
        .i_acc      (w_data_rd_acc),
        .i_hit      (rvalid && (rid == c_data_id)),
        .i_rdata    (rdata),
        .o_can_acc  (w_data_can),
        .o_cnt_zero (w_data_cnt_zero),
        .o_data_ok  (w_data_rd_ok),
        .o_rdata    (w_data_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE: if (w_data_wr_acc) w_wnext = W_SEND;
            W_SEND: if ((!r_aw_valid || awready) && (!r_w_valid || wready)) w_wnext = W_RESP;
            W_RESP: if (w_b_hit) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        w_wr_idle = (r_wstate == W_IDLE);
        w_b_hit   = (r_wstate == W_RESP) && bvalid && (bid == c_data_id);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_valid   <= 1'b0;
            r_w_valid    <= 1'b0;
            r_aw_addr    <= '0;
            r_aw_size    <= '0;
            r_w_strb     <= '0;
            r_w_data     <= '0;
            r_wr_data_ok <= 1'b0;
        end else begin
            r_wr_data_ok <= w_b_hit;
            if (w_data_wr_acc) begin
                r_aw_valid <= 1'b1;
                r_w_valid  <= 1'b1;
                r_aw_addr  <= data_sram_addr;
                r_aw_size  <= {1'b0, data_sram_size};
                r_w_strb   <= data_sram_wstrb;
                r_w_data   <= data_sram_wdata;
            end else begin
                if (awready) r_aw_valid <= 1'b0;
                if (wready)  r_w_valid  <= 1'b0;
            end
        end
    end

    assign inst_sram_addr_ok = w_inst_rd_acc;
    assign data_sram_addr_ok = w_data_rd_acc || w_data_wr_acc;
    // Reads are blocked while a write is live, so the two pulses never overlap.
    assign data_sram_data_ok = w_data_rd_ok || r_wr_data_ok;
    assign data_sram_rdata   = w_data_rd_data;

    assign arid    = r_ar_id;
    assign araddr  = r_ar_addr;
    assign arlen   = 8'd0;
    assign arsize  = r_ar_size;
    assign arburst = BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = r_ar_valid;
    assign rready  = 1'b1;

    assign awid    = c_data_id;
    assign awaddr  = r_aw_addr;
    assign awlen   = 8'd0;
    assign awsize  = r_aw_size;
    assign awburst = BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = r_aw_valid;

    assign wid     = c_data_id;
    assign wdata   = r_w_data;
    assign wstrb   = r_w_strb;
    assign wlast   = 1'b1;
    assign wvalid  = r_w_valid;
    assign bready  = 1'b1;

    logic w_unused_ok;
    assign w_unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast,
                           bresp, w_inst_cnt_zero};

endmodule

`default_nettype wire
